intpol2_d4_squared_seq: RTL and testbench
=========================================

# intpol2_D4_squared_seq

Sequencer and sample-holding front end for the squared-term accumulator `intpol2_D4_squared` in the ×4 quadratic interpolator.
- Accepts one `x2` sample per valid/ready handshake and holds it stable.
- Drives `en_xi2`/`sel_xi2` through the four phases n = 0..3, so the accumulator produces n²·x2.
- Returns each accumulated value downstream on a valid/ready handshake with phase and last-phase tags.

## Interface
Parameters:
- `DATAPATH_WIDTH`, 32, base sample width.
- `N_bits`, 2, growth bits; `W` = `DATAPATH_WIDTH+N_bits`.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `clear`  in  1  synchronous soft reset, active high.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  upstream ready; accept = `in_valid & in_ready`.
- `in_x2`  in  W signed  squared-coefficient sample.
- `x2`  out  W signed  held sample to accumulator.
- `en_xi2`  out  1  accumulator update enable.
- `sel_xi2`  out  2  accumulator mode; equals the current phase.
- `clear_xi2`  out  1  accumulator clear.
- `xi2`  in  W signed  accumulator output.
- `out_valid`  out  1  downstream valid.
- `out_ready`  in  1  downstream ready; transfer = `out_valid & out_ready`.
- `out_xi2`  out  W signed  equals `xi2` (pass-through).
- `out_phase`  out  2  phase n of the presented value.
- `out_last`  out  1  high when `out_phase`==3.

## Operation
- **States:** IDLE, RUN, OUT.
- **Registered state:** `state`, `phase[1:0]`, `x2` register.
- **Reset (rstn low):**
  - State: IDLE, `phase`=0, `x2`=0.
  - Outputs: `en_xi2`=0, `sel_xi2`=0, `out_valid`=0, `clear_xi2`=1.
- **`in_ready`:** combinational, `(state==IDLE) | (state==OUT & phase==3 & out_ready)`.
- **IDLE:** on accept, `x2`←`in_x2`, `phase`←0, go to RUN.
- **RUN:** one cycle only.
  - `en_xi2`=1 and `sel_xi2`=`phase`; go to OUT.
  - Resulting accumulator sequence is 0, x2, 4·x2, 9·x2.
- **OUT:**
  - `out_valid`=1, `out_phase`=`phase`, `out_last`=(`phase`==3), `en_xi2`=0.
  - Without a transfer: hold.
  - Transfer with `phase`<3: `phase`+1, go to RUN.
  - Transfer with `phase`==3 and simultaneous accept: load `x2`, `phase`←0, go to RUN.
  - Transfer with `phase`==3 and no accept: go to IDLE.
- **`sel_xi2` outside RUN:** driven with `phase` but ignored, because `en_xi2`=0.
- **`x2`:** changes only on accept. It is stable through all four phases, because the phase-3 update (mode 11) reads `x2`.
- **Arithmetic:** none in this block. Accumulator results wrap modulo 2^W, and this block does not saturate or detect overflow.
- **`clear`:**
  - `clear_xi2` = `clear | ~rstn` (combinational).
  - Next edge: IDLE, `phase`=0. `x2` is retained.
  - Any in-flight output is dropped; `out_valid`=0 the cycle after.
  - `clear` has priority over a simultaneous accept or transfer; that accept is not taken.
- **Reset mid-operation:** immediate return to reset values; no output is completed.

## Timing
- Accept at edge k → RUN cycle k+1 → `out_valid` in cycle k+2 with phase 0.
- Each phase costs 2 cycles at minimum (RUN + OUT), so a sample takes 8 cycles.
- Back-to-back accept at the phase-3 transfer adds no idle cycle: sustained throughput is 1 sample per 8 cycles.
- `out_valid`, `out_phase` and `out_xi2` stay stable until transfer; `en_xi2` is never high while `out_valid`=1.
- `out_valid` drops in the cycle after a transfer unless the next phase's OUT follows RUN. There is always one RUN cycle with `out_valid`=0 between outputs.

## Test plan
Bench instantiates this block driving `intpol2_D4_squared`.
- **Basic:** W=34, single sample `in_x2`=3, `out_ready`=1 → outputs 0, 3, 12, 27 with phases 0..3.
  - `out_last` high only on 27.
  - First `out_valid` 2 cycles after accept; `in_ready` returns in the cycle of the phase-3 transfer.
- **Negative:** `in_x2`=-5 → 0, -5, -20, -45.
- **Back-to-back:** samples 3 then 7 with `in_valid` held high → 0, 3, 12, 27, 0, 7, 28, 63.
  - 8 cycles per sample; second accept coincides with the transfer of 27.
- **Backpressure:**
  - `out_ready` low for 5 cycles at phase 2 → 12 held stable, `en_xi2`=0 throughout.
  - Then resumes with 27.
  - `in_valid` during the stall is not accepted.
- **Wrap:** `DATAPATH_WIDTH`=6, `N_bits`=2 (W=8), `in_x2`=20 → 0, 20, 80, 180 mod 256 = -76.
- **Clear/reset mid-sample:**
  - `clear` while OUT at phase 1 → `clear_xi2` high that cycle, no further outputs, IDLE.
  - Next sample 2 → 0, 2, 8, 18.
  - Repeat with `rstn` pulsed low asynchronously mid-RUN: identical recovery, `x2`=0 after reset.

Source files
------------

// File: rtl/intpol2_d4_squared_seq_if.sv
// Upstream sample and downstream result handshakes of the
// squared-term sequencer.
interface intpol2_d4_squared_seq_if #(
    parameter int W = 34
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_x2;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_xi2;
    logic [1:0]          out_phase;
    logic                out_last;

    modport slave (
        input  in_valid, in_x2, out_ready,
        output in_ready, out_valid, out_xi2, out_phase, out_last
    );

    modport master (
        output in_valid, in_x2, out_ready,
        input  in_ready, out_valid, out_xi2, out_phase, out_last
    );
endinterface

// File: rtl/intpol2_d4_squared_seq.sv
// Sequencer for the x4 interpolator squared-term accumulator:
// holds one x2 sample and steps the accumulator through n = 0..3.
module intpol2_d4_squared_seq #(
    parameter int DATAPATH_WIDTH = 32,
    parameter int N_bits         = 2,
    localparam int W             = DATAPATH_WIDTH + N_bits
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clear,
    intpol2_d4_squared_seq_if.slave bus,
    output logic signed [W-1:0] x2,
    output logic                en_xi2,
    output logic [1:0]          sel_xi2,
    output logic                clear_xi2,
    input  logic signed [W-1:0] xi2
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [1:0] phase;
    logic [1:0] phase_n;
    logic       load;
    logic       accept;
    logic       xfer;
    logic       last;

    assign last          = (phase == 2'd3);
    assign bus.in_ready  = (state == IDLE)
                         | ((state == OUT) & last & bus.out_ready);
    assign bus.out_valid = (state == OUT);
    assign bus.out_xi2   = xi2;
    assign bus.out_phase = phase;
    assign bus.out_last  = last;
    assign accept        = bus.in_valid & bus.in_ready;
    assign xfer          = bus.out_valid & bus.out_ready;
    assign en_xi2        = (state == RUN);
    assign sel_xi2       = phase;
    assign clear_xi2     = clear | ~rstn;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            phase <= 2'd0;
            x2    <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            if (load) x2 <= bus.in_x2;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        load    = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                if (accept) begin
                    load    = 1'b1;
                    phase_n = 2'd0;
                    state_n = RUN;
                end
            end
            (state == RUN): state_n = OUT;
            (state == OUT): begin
                if (xfer && !last) begin
                    phase_n = phase + 2'd1;
                    state_n = RUN;
                end else if (xfer && accept) begin
                    load    = 1'b1;
                    phase_n = 2'd0;
                    state_n = RUN;
                end else if (xfer) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Soft clear wins over any same-cycle accept or transfer
        if (clear) begin
            load    = 1'b0;
            phase_n = 2'd0;
            state_n = IDLE;
        end
    end
endmodule

// File: tb/tb_intpol2_d4_squared_seq.sv
// Bench for the squared-term sequencer, each instance driving a
// behavioural model of the n^2 accumulator.
module tb_intpol2_d4_squared_seq;
    localparam int WA = 34;
    localparam int WB = 8;

    typedef struct {
        logic signed [WA-1:0] v;
        logic [1:0]           ph;
        logic                 last;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];

    intpol2_d4_squared_seq_if #(.W(WA)) bus_a ();
    intpol2_d4_squared_seq_if #(.W(WB)) bus_b ();

    logic signed [WA-1:0] x2_a, xi2_a;
    logic                 en_a, clr_a;
    logic [1:0]           sel_a;
    logic signed [WB-1:0] x2_b, xi2_b;
    logic                 en_b, clr_b;
    logic [1:0]           sel_b;

    intpol2_d4_squared_seq #(.DATAPATH_WIDTH(32), .N_bits(2)) dut_a (
        .clk(clk), .rstn(rstn), .clear(clear), .bus(bus_a),
        .x2(x2_a), .en_xi2(en_a), .sel_xi2(sel_a),
        .clear_xi2(clr_a), .xi2(xi2_a)
    );

    intpol2_d4_squared_seq #(.DATAPATH_WIDTH(6), .N_bits(2)) dut_b (
        .clk(clk), .rstn(rstn), .clear(1'b0), .bus(bus_b),
        .x2(x2_b), .en_xi2(en_b), .sel_xi2(sel_b),
        .clear_xi2(clr_b), .xi2(xi2_b)
    );

    // Accumulator models: mode n adds (2n-1)*x2, mode 0 zeroes
    always @(posedge clk or negedge rstn) begin
        if (!rstn) xi2_a <= '0;
        else if (clr_a) xi2_a <= '0;
        else if (en_a) begin
            case (sel_a)
                2'd0: xi2_a <= '0;
                2'd1: xi2_a <= xi2_a + x2_a;
                2'd2: xi2_a <= xi2_a + x2_a + x2_a + x2_a;
                default: xi2_a <= xi2_a + (x2_a <<< 2) + x2_a;
            endcase
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) xi2_b <= '0;
        else if (clr_b) xi2_b <= '0;
        else if (en_b) begin
            case (sel_b)
                2'd0: xi2_b <= '0;
                2'd1: xi2_b <= xi2_b + x2_b;
                2'd2: xi2_b <= xi2_b + x2_b + x2_b + x2_b;
                default: xi2_b <= xi2_b + (x2_b <<< 2) + x2_b;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push n^2*x on accept, pop on each transfer
    always @(negedge rstn) q.delete();

    always @(negedge clk) begin
        if (!rstn || clear) begin
            q.delete();
        end else begin
            if (bus_a.out_valid && bus_a.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_xi2", 64'(bus_a.out_xi2), 64'(e.v));
                    check("out_phase", 64'(bus_a.out_phase), 64'(e.ph));
                    check("out_last", 64'(bus_a.out_last), 64'(e.last));
                    check("en_during_valid", 64'(en_a), 64'd0);
                end
            end
            if (bus_a.in_valid && bus_a.in_ready) begin
                for (int n = 0; n < 4; n++) begin
                    exp_t e;
                    logic signed [WA-1:0] xv;
                    xv     = bus_a.in_x2;
                    e.v    = xv * 34'(n * n);
                    e.ph   = 2'(n);
                    e.last = (n == 3);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [WA-1:0] v);
        bit ok = 1'b0;
        bus_a.in_valid = 1'b1;
        bus_a.in_x2    = v;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_a.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_timeout", 64'(ok), 64'd1);
        step();
        bus_a.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus_a.out_valid && bus_a.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", 64'(ok), 64'd1);
        step();
    endtask

    task automatic wait_out(input logic [1:0] ph);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus_a.out_valid && bus_a.out_phase == ph) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_out_timeout", 64'(ok), 64'd1);
    endtask

    task automatic idle_check(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, "_valid"}, 64'(bus_a.out_valid), 64'd0);
            check({tag, "_ready"}, 64'(bus_a.in_ready), 64'd1);
        end
        step();
    endtask

    initial begin
        int cnt;
        bit ok;
        logic signed [WB-1:0] wexp[4];
        bus_a.in_valid = 1'b0; bus_a.in_x2 = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_x2 = '0; bus_b.out_ready = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_en", 64'(en_a), 64'd0);
        check("rst_sel", 64'(sel_a), 64'd0);
        check("rst_clear_xi2", 64'(clr_a), 64'd1);
        check("rst_x2", 64'(x2_a), 64'd0);
        check("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
        step();
        rstn = 1'b1;
        bus_a.out_ready = 1'b1;
        step();

        // Basic: 3 -> 0,3,12,27 with latency checks
        bus_a.in_valid = 1'b1;
        bus_a.in_x2    = 34'sd3;
        step();
        bus_a.in_valid = 1'b0;
        @(negedge clk);
        check("lat_run_en", 64'(en_a), 64'd1);
        check("lat_run_valid", 64'(bus_a.out_valid), 64'd0);
        check("lat_run_x2", 64'(x2_a), 64'd3);
        @(negedge clk);
        check("lat_out_valid", 64'(bus_a.out_valid), 64'd1);
        check("lat_out_phase", 64'(bus_a.out_phase), 64'd0);
        wait_out(2'd3);
        check("ready_at_last", 64'(bus_a.in_ready), 64'd1);
        drain();

        // Negative sample
        send(-34'sd5);
        drain();

        // Back-to-back 3 then 7
        bus_a.in_valid = 1'b1;
        bus_a.in_x2    = 34'sd3;
        @(negedge clk);
        check("b2b_first_ready", 64'(bus_a.in_ready), 64'd1);
        step();
        bus_a.in_x2 = 34'sd7;
        cnt = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt++;
            if (bus_a.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("b2b_found", 64'(ok), 64'd1);
        check("b2b_cycles", 64'(cnt), 64'd8);
        check("b2b_with_last", 64'(bus_a.out_last && bus_a.out_valid), 64'd1);
        step();
        bus_a.in_valid = 1'b0;
        drain();

        // Backpressure at phase 2
        send(34'sd3);
        wait_out(2'd1);
        step();
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_x2     = 34'sd99;
        wait_out(2'd2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_xi2", 64'(bus_a.out_xi2), 64'd12);
            check("stall_valid", 64'(bus_a.out_valid), 64'd1);
            check("stall_en", 64'(en_a), 64'd0);
            check("stall_in_ready", 64'(bus_a.in_ready), 64'd0);
        end
        step();
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        drain();

        // Clear at phase 1, then recovery
        send(34'sd9);
        wait_out(2'd0);
        step();
        bus_a.out_ready = 1'b0;
        wait_out(2'd1);
        step();
        clear = 1'b1;
        @(negedge clk);
        check("clear_xi2_high", 64'(clr_a), 64'd1);
        step();
        clear = 1'b0;
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        check("clear_x2_kept", 64'(x2_a), 64'd9);
        idle_check("after_clear");
        send(34'sd2);
        drain();

        // Async reset mid-RUN, then recovery
        send(34'sd6);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en_a && sel_a == 2'd1) begin
                ok = 1'b1;
                break;
            end
        end
        check("find_run", 64'(ok), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("arst_x2", 64'(x2_a), 64'd0);
        check("arst_valid", 64'(bus_a.out_valid), 64'd0);
        check("arst_en", 64'(en_a), 64'd0);
        check("arst_clear_xi2", 64'(clr_a), 64'd1);
        #1 rstn = 1'b1;
        idle_check("after_rst");
        send(34'sd2);
        drain();

        // Wrap on the 8-bit instance: 20 -> 0,20,80,-76
        wexp[0] = 8'sd0;
        wexp[1] = 8'sd20;
        wexp[2] = 8'sd80;
        wexp[3] = -8'sd76;
        bus_b.in_valid = 1'b1;
        bus_b.in_x2    = 8'sd20;
        @(negedge clk);
        check("wrap_ready", 64'(bus_b.in_ready), 64'd1);
        step();
        bus_b.in_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus_b.out_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("wrap_timeout", 64'(ok), 64'd1);
            check("wrap_xi2", 64'(bus_b.out_xi2), 64'(wexp[n]));
            check("wrap_phase", 64'(bus_b.out_phase), 64'(n));
            check("wrap_last", 64'(bus_b.out_last), 64'(n == 3));
            step();
        end

        check("sb_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
